sram_port_arbiter: RTL and testbench

//  Shares one synchronous single-port SRAM between the CPU instruction-fetch requester
//  and the load/store requester of the multi-cycle core. Sits between mycpu_top and the

---
 rtl/sram_port_arbiter_if.sv | 41 ++++
 rtl/sram_port_arbiter.sv | 98 +++++++++
 tb/tb_sram_port_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// Handshake bundle between the core's fetch / load-store requesters, the arbiter and the unified SRAM.
// The arbiter takes the slave view; the core plus SRAM side takes the master view.
interface sram_port_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        sram_en;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_we, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_we, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and load/store, one access per cycle, 1-cycle response.
// SRAM_ARB_RR_EN selects round-robin on conflict; undefined gives data priority with fetch starvation override.
//
// state  | meaning
// IDLE   | no response due this cycle
// RESP_I | fetch read data returns this cycle
// RESP_D | load data / store ack returns this cycle
module sram_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic               clk,
    input  logic               resetn,
    sram_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } state_t;

    state_t state;
    logic   arb_ready;
    logic   resp_we;
    logic   gnt_i;
    logic   gnt_d;

`ifdef SRAM_ARB_RR_EN
    localparam logic SIDE_D = 1'b0;
    localparam logic SIDE_I = 1'b1;
    logic rr_last;
`else
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    logic [CNT_W-1:0] starve_cnt;
`endif

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (arb_ready) begin
            if (bus.inst_req && bus.data_req) begin
`ifdef SRAM_ARB_RR_EN
                if (rr_last == SIDE_D) gnt_i = 1'b1;
                else                   gnt_d = 1'b1;
`else
                if (starve_cnt == LIMIT) gnt_i = 1'b1;
                else                     gnt_d = 1'b1;
`endif
            end else if (bus.inst_req) begin
                gnt_i = 1'b1;
            end else if (bus.data_req) begin
                gnt_d = 1'b1;
            end
        end
    end

    assign bus.inst_addr_ok = gnt_i;
    assign bus.data_addr_ok = gnt_d;
    assign bus.sram_en      = gnt_i | gnt_d;
    assign bus.sram_we      = gnt_d & bus.data_we;
    assign bus.sram_addr    = gnt_i ? bus.inst_addr : (gnt_d ? bus.data_addr : 32'd0);
    assign bus.sram_wdata   = gnt_d ? bus.data_wdata : 32'd0;

    // Response data is the SRAM output passed straight through; store acks carry zero.
    assign bus.inst_data_ok = (state == RESP_I);
    assign bus.inst_rdata   = (state == RESP_I) ? bus.sram_rdata : 32'd0;
    assign bus.data_data_ok = (state == RESP_D);
    assign bus.data_rdata   = (state == RESP_D && !resp_we) ? bus.sram_rdata : 32'd0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arb_ready  <= 1'b0;
            state      <= IDLE;
            resp_we    <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            rr_last    <= SIDE_D;
`else
            starve_cnt <= '0;
`endif
        end else begin
            arb_ready <= 1'b1;
            resp_we   <= gnt_d & bus.data_we;
            if (gnt_i)      state <= RESP_I;
            else if (gnt_d) state <= RESP_D;
            else            state <= IDLE;
`ifdef SRAM_ARB_RR_EN
            if (gnt_i)      rr_last <= SIDE_I;
            else if (gnt_d) rr_last <= SIDE_D;
`else
            // Counts every cycle fetch waits, including the cycle before arb_ready rises.
            if (!bus.inst_req || gnt_i)  starve_cnt <= '0;
            else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized and directed check of sram_port_arbiter against a grant/memory reference model.
// Build with SRAM_ARB_RR_EN defined to check the round-robin variant.
module tb_sram_port_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    sram_port_arbiter_if bif();

    sram_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif)
    );

    // SRAM behavioural model reacting to the DUT's own SRAM pins
    logic [31:0] sram_mem [0:255];
    logic [31:0] sram_rd_q;
    assign bif.sram_rdata = sram_rd_q;
    always @(posedge clk) begin
        if (bif.sram_en) begin
            if (bif.sram_we) sram_mem[bif.sram_addr[9:2]] <= bif.sram_wdata;
            else             sram_rd_q <= sram_mem[bif.sram_addr[9:2]];
        end
    end

    // reference model state
    logic [31:0] ref_mem [0:255];
    bit          m_ready;
    int          m_streak;
    bit          m_rr_last_i;
    int          m_resp_kind;   // 0 none, 1 fetch, 2 load, 3 store
    logic [31:0] m_resp_val;

    int checks = 0;
    int errors = 0;

    logic        cap_inst_ok, cap_data_ok, cap_inst_dok, cap_data_dok, cap_sram_we;
    logic [31:0] cap_inst_rdata, cap_data_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ready     = 1'b0;
        m_streak    = 0;
        m_rr_last_i = 1'b0;
        m_resp_kind = 0;
        m_resp_val  = 32'd0;
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic cycle(output bit gi, output bit gd);
        bit          ei, ed;
        logic [31:0] ea, ew;
        @(negedge clk);
        ei = 1'b0;
        ed = 1'b0;
        if (m_ready) begin
            if (bif.inst_req && bif.data_req) begin
`ifdef SRAM_ARB_RR_EN
                if (m_rr_last_i) ed = 1'b1;
                else             ei = 1'b1;
`else
                if (m_streak >= STARVE_LIMIT) ei = 1'b1;
                else                          ed = 1'b1;
`endif
            end else begin
                ei = bif.inst_req;
                ed = bif.data_req;
            end
        end
        ea = ei ? bif.inst_addr : (ed ? bif.data_addr : 32'd0);
        ew = ed ? bif.data_wdata : 32'd0;
        chk("inst_addr_ok", {31'd0, bif.inst_addr_ok}, {31'd0, ei});
        chk("data_addr_ok", {31'd0, bif.data_addr_ok}, {31'd0, ed});
        chk("sram_en",      {31'd0, bif.sram_en},      {31'd0, ei | ed});
        chk("sram_we",      {31'd0, bif.sram_we},      {31'd0, ed & bif.data_we});
        chk("sram_addr",    bif.sram_addr,  ea);
        chk("sram_wdata",   bif.sram_wdata, ew);
        chk("inst_data_ok", {31'd0, bif.inst_data_ok}, {31'd0, m_resp_kind == 1});
        chk("inst_rdata",   bif.inst_rdata, (m_resp_kind == 1) ? m_resp_val : 32'd0);
        chk("data_data_ok", {31'd0, bif.data_data_ok}, {31'd0, m_resp_kind >= 2});
        chk("data_rdata",   bif.data_rdata, (m_resp_kind == 2) ? m_resp_val : 32'd0);
        cap_inst_ok    = bif.inst_addr_ok;
        cap_data_ok    = bif.data_addr_ok;
        cap_inst_dok   = bif.inst_data_ok;
        cap_data_dok   = bif.data_data_ok;
        cap_sram_we    = bif.sram_we;
        cap_inst_rdata = bif.inst_rdata;
        cap_data_rdata = bif.data_rdata;
        @(posedge clk);
        if (resetn) begin
            m_ready = 1'b1;
            if (ei) begin
                m_resp_kind = 1;
                m_resp_val  = ref_mem[ea[9:2]];
            end else if (ed && bif.data_we) begin
                ref_mem[ea[9:2]] = bif.data_wdata;
                m_resp_kind = 3;
                m_resp_val  = 32'd0;
            end else if (ed) begin
                m_resp_kind = 2;
                m_resp_val  = ref_mem[ea[9:2]];
            end else begin
                m_resp_kind = 0;
            end
            if (bif.inst_req && !ei) m_streak = (m_streak < STARVE_LIMIT) ? m_streak + 1 : STARVE_LIMIT;
            else                     m_streak = 0;
            if (ei)      m_rr_last_i = 1'b1;
            else if (ed) m_rr_last_i = 1'b0;
        end
        gi = ei;
        gd = ed;
        #1;
    endtask

    initial begin
        bit          gi, gd;
        logic [31:0] w;
        for (int i = 0; i < 256; i++) begin
            w = 32'h5a000000 ^ (i * 32'h01010101);
            sram_mem[i] = w;
            ref_mem[i]  = w;
        end
        sram_mem[0] = 32'h02800c0c;
        ref_mem[0]  = 32'h02800c0c;
        sram_rd_q   = 32'd0;

        // reset held with a pending fetch: everything quiet, first grant on 2nd edge after release
        bif.inst_req   = 1'b1;
        bif.inst_addr  = 32'h1c000000;
        bif.data_req   = 1'b0;
        bif.data_we    = 1'b0;
        bif.data_addr  = 32'd0;
        bif.data_wdata = 32'd0;
        resetn = 1'b0;
        model_reset();
        cycle(gi, gd);
        cycle(gi, gd);
        resetn = 1'b1;
        cycle(gi, gd);
        chk("t1_no_grant_first_edge", {31'd0, cap_inst_ok}, 32'd0);
        cycle(gi, gd);
        chk("t2_fetch_granted", {31'd0, cap_inst_ok}, 32'd1);
        bif.inst_req = 1'b0;
        cycle(gi, gd);
        chk("t2_fetch_data_ok", {31'd0, cap_inst_dok}, 32'd1);
        chk("t2_fetch_rdata", cap_inst_rdata, 32'h02800c0c);

        // store then load to the same word
        bif.data_req   = 1'b1;
        bif.data_we    = 1'b1;
        bif.data_addr  = 32'h00000100;
        bif.data_wdata = 32'hdeadbeef;
        cycle(gi, gd);
        chk("t3_store_we", {31'd0, cap_sram_we}, 32'd1);
        bif.data_we = 1'b0;
        cycle(gi, gd);
        chk("t3_store_ack", {31'd0, cap_data_dok}, 32'd1);
        chk("t3_store_ack_rdata", cap_data_rdata, 32'd0);
        bif.data_req = 1'b0;
        cycle(gi, gd);
        chk("t3_load_rdata", cap_data_rdata, 32'hdeadbeef);

        // both sides requesting every cycle
        bif.inst_req = 1'b1;
        bif.data_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle(gi, gd);
`ifdef SRAM_ARB_RR_EN
            chk("t5_rr_fetch_turn", {31'd0, cap_inst_ok}, {31'd0, (k % 2) == 0});
`else
            chk("t4_prio_fetch_turn", {31'd0, cap_inst_ok}, {31'd0, (k % 5) == 4});
`endif
            if (gi) bif.inst_addr = bif.inst_addr + 32'd4;
            if (gd) bif.data_addr = bif.data_addr + 32'd4;
        end

        // reset the cycle after a data grant: its response must never appear
        bif.inst_req  = 1'b0;
        bif.data_req  = 1'b1;
        bif.data_we   = 1'b0;
        cycle(gi, gd);
        cycle(gi, gd);
        chk("t6_data_granted", {31'd0, cap_data_ok}, 32'd1);
        bif.data_req = 1'b0;
        resetn = 1'b0;
        model_reset();
        cycle(gi, gd);
        chk("t6_no_data_ok_in_reset", {31'd0, cap_data_dok}, 32'd0);
        resetn = 1'b1;
        cycle(gi, gd);
        chk("t6_no_data_ok_after_reset", {31'd0, cap_data_dok}, 32'd0);
        cycle(gi, gd);

        // random traffic with held requests, occasional drops and occasional resets
        for (int n = 0; n < 800; n++) begin
            if (!bif.inst_req) begin
                if ($urandom_range(0, 2) != 0) begin
                    bif.inst_req  = 1'b1;
                    bif.inst_addr = $urandom & 32'hfffffffc;
                end
            end else if ($urandom_range(0, 11) == 0) begin
                bif.inst_req = 1'b0;
            end
            if (!bif.data_req) begin
                if ($urandom_range(0, 2) != 0) begin
                    bif.data_req   = 1'b1;
                    bif.data_we    = $urandom_range(0, 1) == 1;
                    bif.data_addr  = $urandom & 32'h000003fc;
                    bif.data_wdata = $urandom;
                end
            end else if ($urandom_range(0, 11) == 0) begin
                bif.data_req = 1'b0;
            end
            if ($urandom_range(0, 60) == 0) begin
                resetn = 1'b0;
                model_reset();
                cycle(gi, gd);
                resetn = 1'b1;
            end
            cycle(gi, gd);
            if (gi) bif.inst_req = 1'b0;
            if (gd) bif.data_req = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
